// File: rtl/decode_scoreboard.sv
// -----------------------------------------------------------------------------
// decode_scoreboard
//
// Per-register write-pending scoreboard for the decode stage. Each multi-cycle
// execution unit owns one entry (state, destination tag, write enable,
// latency counter). Decode presents a candidate instruction. The block returns
// a stall for RAW, WAW or structural hazards. Execute reports completion
// (done) or abort (kill) per unit.
//
// Ports:
//   clock, reset          clock; synchronous active-low reset
//   issue_*               multi-cycle instruction candidate: unit, rd, rs1, rs2
//   chk_*                 operands of a single-cycle instruction (RAW check only)
//   flush                 decode clear; blocks acceptance this cycle
//   done[k]               completion pulse, used by variable-latency units only
//   kill[k]               abort the outstanding op of unit k (no writeback)
//   stall                 hold decode
//   finish[k]             unit k completes this cycle
//   unit_busy[k]          unit k has an outstanding op
//   busy_mask[r]          register r has a pending write
// -----------------------------------------------------------------------------
module decode_scoreboard #(
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NUNITS = 4,
  parameter int UW     = 2,
  parameter int CW     = 6,
  parameter logic [NUNITS*CW-1:0] UNIT_LAT = {6'd3, 6'd2, 6'd0, 6'd0}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [UW-1:0]     issue_unit,
  input  logic              issue_wren,
  input  logic [AW-1:0]     issue_waddr,
  input  logic              issue_rden1,
  input  logic [AW-1:0]     issue_raddr1,
  input  logic              issue_rden2,
  input  logic [AW-1:0]     issue_raddr2,
  input  logic              chk_rden1,
  input  logic [AW-1:0]     chk_raddr1,
  input  logic              chk_rden2,
  input  logic [AW-1:0]     chk_raddr2,
  input  logic              flush,
  input  logic [NUNITS-1:0] done,
  input  logic [NUNITS-1:0] kill,
  output logic              stall,
  output logic [NUNITS-1:0] finish,
  output logic [NUNITS-1:0] unit_busy,
  output logic [NREGS-1:0]  busy_mask
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} unit_state_t;

  unit_state_t     state_q [NUNITS];
  unit_state_t     state_d [NUNITS];
  logic [AW-1:0]   tag_q   [NUNITS];
  logic [AW-1:0]   tag_d   [NUNITS];
  logic            wren_q  [NUNITS];
  logic            wren_d  [NUNITS];
  logic [CW-1:0]   cnt_q   [NUNITS];
  logic [CW-1:0]   cnt_d   [NUNITS];

  logic [NUNITS-1:0] release_w;
  logic [NREGS-1:0]  release_mask;
  logic [NREGS-1:0]  pend_mask;
  logic              raw_hit;
  logic              waw_hit;
  logic              struct_hit;
  logic              accept;

  // Per-unit release condition and status outputs.
  genvar gi;
  generate
    for (gi = 0; gi < NUNITS; gi++) begin : g_unit
      localparam logic [CW-1:0] LAT   = UNIT_LAT[CW*gi +: CW];
      localparam bit            FIXED = (LAT != '0);
      if (FIXED) begin : g_fixed
        assign release_w[gi] = (state_q[gi] == BUSY) && (cnt_q[gi] == '0);
      end else begin : g_var
        assign release_w[gi] = (state_q[gi] == BUSY) && done[gi];
      end
      assign finish[gi]    = release_w[gi] & ~kill[gi];
      assign unit_busy[gi] = (state_q[gi] == BUSY);
    end
  endgenerate

  // Pending-write bitmap from registered state, plus the tags being released
  // this cycle. x0 is never marked, so it can never cause a stall.
  always_comb begin
    busy_mask    = '0;
    release_mask = '0;
    for (int k = 0; k < NUNITS; k++) begin
      if (state_q[k] == BUSY && wren_q[k] && tag_q[k] != '0) begin
        busy_mask[tag_q[k]] = 1'b1;
        if (release_w[k]) begin
          release_mask[tag_q[k]] = 1'b1;
        end
      end
    end
  end

  // A releasing tag is not pending: forwarding supplies its result this cycle.
  assign pend_mask = busy_mask & ~release_mask;

  always_comb begin
    raw_hit    = 1'b0;
    waw_hit    = 1'b0;
    struct_hit = 1'b0;
    if (chk_rden1 && chk_raddr1 != '0 && pend_mask[chk_raddr1]) raw_hit = 1'b1;
    if (chk_rden2 && chk_raddr2 != '0 && pend_mask[chk_raddr2]) raw_hit = 1'b1;
    if (issue_valid) begin
      if (issue_rden1 && issue_raddr1 != '0 && pend_mask[issue_raddr1]) raw_hit = 1'b1;
      if (issue_rden2 && issue_raddr2 != '0 && pend_mask[issue_raddr2]) raw_hit = 1'b1;
      if (issue_wren && issue_waddr != '0 && pend_mask[issue_waddr]) waw_hit = 1'b1;
      // Out-of-range unit indices never raise a structural stall.
      if (int'(issue_unit) < NUNITS) begin
        if (state_q[issue_unit] == BUSY && !release_w[issue_unit] && !kill[issue_unit]) begin
          struct_hit = 1'b1;
        end
      end
    end
  end

  assign stall  = raw_hit | waw_hit | struct_hit;
  assign accept = issue_valid & ~stall & ~flush;

  // Next state. A unit that releases or is killed returns to IDLE, unless a
  // new op is accepted into it in the same cycle. In that case the new op loads.
  always_comb begin
    for (int k = 0; k < NUNITS; k++) begin
      state_d[k] = state_q[k];
      tag_d[k]   = tag_q[k];
      wren_d[k]  = wren_q[k];
      cnt_d[k]   = cnt_q[k];
      if (state_q[k] == BUSY) begin
        if (release_w[k] || kill[k]) begin
          state_d[k] = IDLE;
        end else if (cnt_q[k] != '0) begin
          cnt_d[k] = cnt_q[k] - 1'b1;
        end
      end
      if (accept && int'(issue_unit) == k) begin
        state_d[k] = BUSY;
        tag_d[k]   = issue_waddr;
        wren_d[k]  = issue_wren;
        // Fixed units count down L-1 to 0. Variable units keep the counter at 0.
        if (UNIT_LAT[CW*k +: CW] != '0) begin
          cnt_d[k] = UNIT_LAT[CW*k +: CW] - 1'b1;
        end else begin
          cnt_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < NUNITS; k++) begin
      if (!reset) begin
        state_q[k] <= IDLE;
        tag_q[k]   <= '0;
        wren_q[k]  <= 1'b0;
        cnt_q[k]   <= '0;
      end else begin
        state_q[k] <= state_d[k];
        tag_q[k]   <= tag_d[k];
        wren_q[k]  <= wren_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_decode_scoreboard
//
// Directed bench for decode_scoreboard with the default unit mix:
// unit0 variable, unit1 variable, unit2 L=2, unit3 L=3.
// Inputs change 1 ns after the rising edge. Outputs are sampled 2 ns later.
// -----------------------------------------------------------------------------
module tb_decode_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [1:0]  issue_unit;
  logic        issue_wren;
  logic [4:0]  issue_waddr;
  logic        issue_rden1;
  logic [4:0]  issue_raddr1;
  logic        issue_rden2;
  logic [4:0]  issue_raddr2;
  logic        chk_rden1;
  logic [4:0]  chk_raddr1;
  logic        chk_rden2;
  logic [4:0]  chk_raddr2;
  logic        flush;
  logic [3:0]  done;
  logic [3:0]  kill;
  logic        stall;
  logic [3:0]  finish;
  logic [3:0]  unit_busy;
  logic [31:0] busy_mask;

  int n_tests = 0;
  int n_fail  = 0;

  decode_scoreboard dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_unit(issue_unit),
    .issue_wren(issue_wren), .issue_waddr(issue_waddr),
    .issue_rden1(issue_rden1), .issue_raddr1(issue_raddr1),
    .issue_rden2(issue_rden2), .issue_raddr2(issue_raddr2),
    .chk_rden1(chk_rden1), .chk_raddr1(chk_raddr1),
    .chk_rden2(chk_rden2), .chk_raddr2(chk_raddr2),
    .flush(flush), .done(done), .kill(kill),
    .stall(stall), .finish(finish), .unit_busy(unit_busy), .busy_mask(busy_mask)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_unit = 0; issue_wren = 0; issue_waddr = 0;
    issue_rden1 = 0; issue_raddr1 = 0; issue_rden2 = 0; issue_raddr2 = 0;
    chk_rden1 = 0; chk_raddr1 = 0; chk_rden2 = 0; chk_raddr2 = 0;
    flush = 0; done = 0; kill = 0;
  endtask

  task automatic issue(input logic [1:0] u, input logic [4:0] rd, input logic we);
    issue_valid = 1; issue_unit = u; issue_waddr = rd; issue_wren = we;
  endtask

  // Advance to the next cycle: inputs may change at edge + 1 ns.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle against the current inputs.
  task automatic settle();
    #2;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    next_cycle();
    next_cycle();
    chk_rden1 = 1; chk_raddr1 = 5;
    settle();
    check("rst_unit_busy", unit_busy, 0);
    check("rst_busy_mask", busy_mask, 0);
    check("rst_finish", finish, 0);
    check("rst_stall", stall, 0);
    idle_inputs();
    reset = 1;
    next_cycle();

    // 1: variable-latency divider (unit1), rd=5, released by done[1].
    issue(1, 5, 1);
    settle(); check("t1_issue_stall", stall, 0);
    next_cycle();
    idle_inputs(); chk_rden1 = 1; chk_raddr1 = 5;
    settle();
    check("t1_chk_stall", stall, 1);
    check("t1_busy_mask", busy_mask, 32'h20);
    check("t1_unit_busy", unit_busy, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); settle();
      check("t1_wait_stall", stall, 1);
    end
    next_cycle();
    done = 4'b0010;
    settle();
    check("t1_done_stall", stall, 0);
    check("t1_done_finish", finish, 4'b0010);
    next_cycle();
    done = 0;
    settle();
    check("t1_after_mask", busy_mask, 0);
    check("t1_after_busy", unit_busy, 0);
    check("t1_after_stall", stall, 0);
    idle_inputs();

    // 2: fixed L=2 (unit2), rd=7. A chk rs2 and an issue rs1 both depend on it.
    issue(2, 7, 1);
    next_cycle();
    idle_inputs();
    chk_rden2 = 1; chk_raddr2 = 7;
    settle();
    check("t2_T1_chk_stall", stall, 1);
    check("t2_T1_finish", finish, 0);
    chk_rden2 = 0;
    issue(0, 0, 0); issue_rden1 = 1; issue_raddr1 = 7;
    settle();
    check("t2_T1_issue_raw", stall, 1);
    next_cycle();
    settle();
    check("t2_T2_issue_stall", stall, 0);
    check("t2_T2_finish", finish, 4'b0100);
    check("t2_T2_mask", busy_mask, 32'h80);
    next_cycle();
    idle_inputs(); chk_rden2 = 1; chk_raddr2 = 7;
    settle();
    check("t2_T3_busy", unit_busy, 4'b0001);
    check("t2_T3_mask", busy_mask, 0);
    check("t2_T3_stall", stall, 0);
    chk_rden2 = 0; done = 4'b0001;
    settle();
    check("t2_u0_finish", finish, 4'b0001);
    next_cycle();
    idle_inputs();
    settle(); check("t2_idle", unit_busy, 0);

    // 3: structural hazard on unit3 (L=3) and flush.
    issue(3, 9, 1);
    next_cycle();
    issue(3, 10, 1); flush = 1;
    settle();
    check("t3_struct_stall", stall, 1);
    next_cycle();
    flush = 0; issue_valid = 0;
    settle();
    check("t3_mask_unchanged", busy_mask, 32'h200);
    check("t3_busy_unchanged", unit_busy, 4'b1000);
    check("t3_T2_finish", finish, 0);
    next_cycle();
    issue(3, 10, 1);
    settle();
    check("t3_T3_finish", finish, 4'b1000);
    check("t3_T3_reissue_stall", stall, 0);
    next_cycle();
    idle_inputs();
    settle();
    check("t3_reissue_mask", busy_mask, 32'h400);
    check("t3_reissue_busy", unit_busy, 4'b1000);
    next_cycle(); next_cycle();
    settle(); check("t3_reissue_finish", finish, 4'b1000);
    next_cycle();
    settle(); check("t3_idle", unit_busy, 0);

    // 4: WAW on rd=4 between unit1 and unit2, then x0 never stalls.
    issue(1, 4, 1);
    next_cycle();
    issue(2, 4, 1);
    settle(); check("t4_waw_stall", stall, 1);
    next_cycle();
    settle();
    check("t4_waw_stall2", stall, 1);
    check("t4_waw_busy", unit_busy, 4'b0010);
    next_cycle();
    done = 4'b0010;
    settle();
    check("t4_release_stall", stall, 0);
    check("t4_release_finish", finish, 4'b0010);
    next_cycle();
    idle_inputs();
    settle();
    check("t4_u2_busy", unit_busy, 4'b0100);
    check("t4_u2_mask", busy_mask, 32'h10);
    next_cycle();
    settle(); check("t4_u2_finish", finish, 4'b0100);
    next_cycle();
    issue(0, 0, 1); issue_rden1 = 1; issue_rden2 = 1;
    settle(); check("t4_x0_issue_stall", stall, 0);
    next_cycle();
    idle_inputs(); chk_rden1 = 1; chk_raddr1 = 0;
    issue(1, 0, 1);
    settle();
    check("t4_x0_mask", busy_mask, 0);
    check("t4_x0_stall", stall, 0);
    next_cycle();
    idle_inputs();
    done = 4'b0011;
    settle();
    check("t4_x0_busy", unit_busy, 4'b0011);
    check("t4_x0_finish", finish, 4'b0011);
    next_cycle();
    idle_inputs();
    settle(); check("t4_idle", unit_busy, 0);

    // 5: kill together with done on unit1, same-cycle re-issue accepted.
    issue(1, 6, 1);
    next_cycle();
    issue(1, 8, 1); kill = 4'b0010; done = 4'b0010;
    settle();
    check("t5_kill_stall", stall, 0);
    check("t5_kill_finish", finish, 0);
    next_cycle();
    idle_inputs();
    settle();
    check("t5_new_mask", busy_mask, 32'h100);
    check("t5_new_busy", unit_busy, 4'b0010);
    done = 4'b0010;
    settle(); check("t5_new_finish", finish, 4'b0010);
    next_cycle();
    idle_inputs();
    settle(); check("t5_idle", unit_busy, 0);

    // 6: reset while unit2 has counter=1. The aborted op never finishes.
    issue(2, 3, 1);
    next_cycle();
    idle_inputs();
    reset = 0;
    next_cycle();
    chk_rden1 = 1; chk_raddr1 = 3;
    settle();
    check("t6_rst_busy", unit_busy, 0);
    check("t6_rst_mask", busy_mask, 0);
    check("t6_rst_finish", finish, 0);
    check("t6_rst_stall", stall, 0);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); settle();
      check("t6_no_finish", finish, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
